// File: rtl/posit_dot_seq.sv
// posit_dot_seq: framed dot-product sequencer around an 8-bit posit (es=0) MAC.
//
// A start pulse in IDLE latches a vector length. The block then accepts that
// many (in_a, in_b) pairs over a valid/ready handshake. For each accepted pair
// it computes acc <- round(in_a * in_b + acc). After the last pair it presents
// acc on a valid/ready result port. A len=0 frame goes straight to the result.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, len            frame command and vector length (sampled in IDLE only)
//   in_valid, in_ready    operand handshake (in_ready high only while accumulating)
//   in_a, in_b            posit operands
//   out_valid, out_ready  result handshake
//   out_data              dot-product result (the accumulator register)
//   busy                  high whenever a frame is in progress
//   nar_seen              sticky: an accepted operand (or bias) was NaR this frame
//   bias                  (POSIT_DOT_BIAS_EN only) initial accumulator value,
//                         sampled with start
//
// Build option: define POSIT_DOT_BIAS_EN to add the bias input.
//
// posit_mac_8bit: combinational fused multiply-add res = round(in_a*in_b + in_c)
// with a single round-to-nearest-even, saturation to +/-maxpos, no underflow
// to zero, and NaR (0x80) propagation.

module posit_dot_seq #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             busy,
  output logic             nar_seen
`ifdef POSIT_DOT_BIAS_EN
  ,
  input  logic [7:0]       bias
`endif
);

  localparam logic [7:0] NAR = 8'h80;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       acc_q, acc_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             nar_q, nar_d;
  logic [7:0]       mac_res;
  logic [7:0]       init_acc;
  logic             init_nar;

`ifdef POSIT_DOT_BIAS_EN
  assign init_acc = bias;
  assign init_nar = (bias == NAR);
`else
  assign init_acc = 8'h00;
  assign init_nar = 1'b0;
`endif

  posit_mac_8bit u_mac (
    .in_a (in_a),
    .in_b (in_b),
    .in_c (acc_q),
    .res  (mac_res)
  );

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    nar_d   = nar_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = init_acc;
          nar_d = init_nar;
          if (len != '0) begin
            count_d = len;
            state_d = ACCUM;
          end else begin
            state_d = DONE;
          end
        end
      end
      ACCUM: begin
        // in_ready is high for the whole state, so in_valid alone is acceptance.
        if (in_valid) begin
          acc_d   = mac_res;
          count_d = count_q - LEN_W'(1);
          nar_d   = nar_q | (in_a == NAR) | (in_b == NAR);
          if (count_q == LEN_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        // start is deliberately not looked at here, even on the handshake cycle.
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= 8'h00;
      count_q <= '0;
      nar_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      nar_q   <= nar_d;
    end
  end

  // The accumulator only changes on accepted pairs or start, so it is stable
  // for the whole DONE state and can drive out_data directly.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = acc_q;
  assign nar_seen  = nar_q;

endmodule

module posit_mac_8bit (
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic [7:0] in_c,
  output logic [7:0] res
);

  localparam logic [7:0] NAR = 8'h80;

  // Every es=0 8-bit posit is an exact multiple of 2^-6 with magnitude <= 64,
  // so decoding to fixed point scaled by 2^6 is lossless. Products are then
  // scaled by 2^12 and the sum stays exact within 28 signed bits.
  function automatic logic signed [27:0] decode(input logic [7:0] p);
    logic [6:0]  mag;
    logic        r0;
    int          run;
    int          k;
    int          nf;
    logic [6:0]  frac;
    logic [13:0] fixed_u;
    mag = p[7] ? (~p[6:0] + 7'd1) : p[6:0];
    r0  = mag[6];
    run = 0;
    for (int i = 6; i >= 0; i--) begin
      if (mag[i] == r0 && run == 6 - i) run++;
    end
    k  = r0 ? run - 1 : -run;
    nf = (run >= 6) ? 0 : 6 - run;
    frac    = mag & ((7'd1 << nf) - 7'd1);
    // Shift is k+6-nf, never negative for es=0.
    fixed_u = ({7'd0, frac} | (14'd1 << nf)) << (k + 6 - nf);
    if (p == 8'h00) fixed_u = '0;
    return p[7] ? -{14'd0, fixed_u} : {14'd0, fixed_u};
  endfunction

  // Builds the unbounded posit bit string (regime then every fraction bit
  // below the leading one), keeps 7 body bits and rounds to nearest even on
  // the string. A round-up carry walks naturally into the next regime.
  function automatic logic [7:0] encode(input logic signed [27:0] v);
    logic [27:0] m;
    int          msb;
    int          k;
    int          rlen;
    logic [6:0]  reg_bits;
    logic [33:0] aligned;
    logic [6:0]  body;
    logic        rnd;
    m        = v[27] ? -v : v;
    msb      = 0;
    rlen     = 0;
    reg_bits = '0;
    aligned  = '0;
    rnd      = 1'b0;
    for (int i = 0; i < 28; i++) begin
      if (m[i]) msb = i;
    end
    k = msb - 12;
    if (m == '0) return 8'h00;
    if (k >= 6) begin
      body = 7'h7F;           // saturate to maxpos
    end else if (k < -6) begin
      body = 7'h01;           // never round a nonzero value to zero
    end else begin
      if (k >= 0) begin
        rlen     = k + 2;
        reg_bits = ((7'd1 << (k + 1)) - 7'd1) << 1;
      end else begin
        rlen     = 1 - k;
        reg_bits = 7'd1;
      end
      aligned = {reg_bits, 27'(m << (27 - msb))} << (7 - rlen);
      rnd     = aligned[26] & ((|aligned[25:0]) | aligned[27]);
      body    = aligned[33:27] + {6'd0, rnd};
    end
    return v[27] ? -{1'b0, body} : {1'b0, body};
  endfunction

  always_comb begin
    if (in_a == NAR || in_b == NAR || in_c == NAR) begin
      res = NAR;
    end else begin
      res = encode(decode(in_a) * decode(in_b) + (decode(in_c) <<< 6));
    end
  end

endmodule

// File: tb/tb_posit_dot_seq.sv
// Testbench for posit_dot_seq: table of directed frames, hand-written
// sequences for reset, latency and len=0, and random frames checked against
// a real-valued reference model (exact sum, then nearest-posit search).
// Define POSIT_DOT_BIAS_EN here as for the RTL to exercise the bias input.

module tb_posit_dot_seq;

  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_a = 8'h00;
  logic [7:0]       in_b = 8'h00;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [7:0]       out_data;
  logic             busy;
  logic             nar_seen;
`ifdef POSIT_DOT_BIAS_EN
  logic [7:0]       bias = 8'h00;
`endif

  posit_dot_seq #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .nar_seen  (nar_seen)
`ifdef POSIT_DOT_BIAS_EN
    ,
    .bias      (bias)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  real pval[256];

  function automatic real posit_value(input logic [7:0] p);
    logic [7:0] m;
    logic [6:0] b;
    logic       r0;
    int         i, run, k;
    real        f, w, v;
    if (p == 8'h00) return 0.0;
    m  = p[7] ? (~p + 8'd1) : p;
    b  = m[6:0];
    r0 = b[6];
    i  = 6;
    run = 0;
    while (i >= 0 && b[i] == r0) begin
      run++;
      i--;
    end
    i--;
    k = r0 ? run - 1 : -run;
    f = 1.0;
    w = 0.5;
    while (i >= 0) begin
      if (b[i]) f = f + w;
      w = w / 2.0;
      i--;
    end
    v = f;
    if (k >= 0) repeat (k) v = v * 2.0;
    else repeat (-k) v = v / 2.0;
    return p[7] ? -v : v;
  endfunction

  // Nearest nonzero posit; ties go to the even bit pattern.
  function automatic logic [7:0] to_posit(input real x);
    int  best;
    real bestd, d;
    if (x == 0.0) return 8'h00;
    best  = 1;
    bestd = 1.0e30;
    for (int p = 1; p < 256; p++) begin
      if (p == 128) continue;
      d = x - pval[p];
      if (d < 0.0) d = -d;
      if (d < bestd || (d == bestd && (p % 2) == 0)) begin
        best  = p;
        bestd = d;
      end
    end
    return 8'(best);
  endfunction

  function automatic logic [7:0] mac_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c);
    if (a == 8'h80 || b == 8'h80 || c == 8'h80) return 8'h80;
    return to_posit(pval[a] * pval[b] + pval[c]);
  endfunction

  // ---------------- frame driver ----------------
  logic [7:0] fa[256];
  logic [7:0] fb[256];
  int         flen;

  function automatic logic [7:0] init_model();
`ifdef POSIT_DOT_BIAS_EN
    return bias;
`else
    return 8'h00;
`endif
  endfunction

  function automatic logic [7:0] frame_model(output logic nar);
    logic [7:0] acc;
    acc = init_model();
    nar = (acc == 8'h80);
    for (int j = 0; j < flen; j++) begin
      acc = mac_model(fa[j], fb[j], acc);
      if (fa[j] == 8'h80 || fb[j] == 8'h80) nar = 1'b1;
    end
    return acc;
  endfunction

  // gap < 0: random 0..2 idle cycles before each pair; otherwise fixed.
  // noise: toggle start/len while the frame is busy (must be ignored).
  task automatic run_frame(input string tag, input int gap, input int hold, input bit noise,
                           output logic [7:0] res, output logic nar);
    int g;
    @(negedge clk);
    start = 1'b1;
    len   = LEN_W'(flen);
    @(negedge clk);
    start = 1'b0;
    if (noise) len = LEN_W'($urandom);
    for (int i = 0; i < flen; i++) begin
      g = (gap < 0) ? $urandom_range(2) : gap;
      repeat (g) begin
        in_valid = 1'b0;
        in_a = 8'($urandom);
        in_b = 8'($urandom);
        if (noise) start = 1'($urandom_range(1));
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_a = fa[i];
      in_b = fb[i];
      if (noise) begin
        start = 1'($urandom_range(1));
        len   = LEN_W'($urandom);
      end
      check($sformatf("%s in_ready pair %0d", tag, i), in_ready, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check({tag, " out_valid at done"}, out_valid, 1);
    check({tag, " in_ready at done"}, in_ready, 0);
    res = out_data;
    nar = nar_seen;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, " out_valid held"}, out_valid, 1);
      check({tag, " out_data stable"}, out_data, res);
      check({tag, " in_ready in done"}, in_ready, 0);
    end
    out_ready = 1'b1;
    if (noise) start = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    check({tag, " out_valid after handshake"}, out_valid, 0);
    check({tag, " busy after handshake"}, busy, 0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int         n;
    logic [31:0] a;     // byte i = operand A of pair i
    logic [31:0] b;
    int         gap;
    int         hold;
    bit         noise;
    logic [7:0] exp_res;
    bit         exp_nar;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [7:0] res, exp;
    logic       nar, exp_nar;

    for (int p = 0; p < 256; p++) pval[p] = posit_value(8'(p));

    tbl[0] = '{4, 32'h40404040, 32'h40404040, 0, 0, 1'b0, 8'h70, 1'b0};
    tbl[1] = '{3, 32'h00404040, 32'h00404040, 2, 3, 1'b0, 8'h68, 1'b0};
    tbl[2] = '{3, 32'h00408040, 32'h00404040, 0, 1, 1'b0, 8'h80, 1'b1};
    tbl[3] = '{3, 32'h00404040, 32'h00404040, 1, 1, 1'b1, 8'h68, 1'b0};
    tbl[4] = '{2, 32'h0000C060, 32'h00004060, 0, 0, 1'b0, 8'h68, 1'b0};
    tbl[5] = '{1, 32'h0000007F, 32'h0000007F, 0, 0, 1'b0, 8'h7F, 1'b0};
    tbl[6] = '{1, 32'h00000001, 32'h00000001, 0, 0, 1'b0, 8'h01, 1'b0};
    tbl[7] = '{2, 32'h0000817F, 32'h00007F7F, 0, 0, 1'b0, 8'h81, 1'b0};
    tbl[8] = '{2, 32'h00000040, 32'h00005540, 0, 0, 1'b0, 8'h40, 1'b0};
    tbl[9] = '{1, 32'h00000040, 32'h00000060, 0, 0, 1'b0, 8'h60, 1'b0};

    // Reset values.
    @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset in_ready", in_ready, 0);
    check("reset busy", busy, 0);
    check("reset out_data", out_data, 8'h00);
    check("reset nar_seen", nar_seen, 0);
    rst_n = 1'b1;

    // Asynchronous reset after 2 of 4 pairs (one of them NaR), then a fresh frame.
    @(negedge clk);
    start = 1'b1;
    len   = 8'd4;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_a = 8'h80;
    in_b = 8'h40;
    @(negedge clk);
    in_a = 8'h40;
    @(negedge clk);
    in_valid = 1'b0;
    check("mid-frame busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort out_valid", out_valid, 0);
    check("abort in_ready", in_ready, 0);
    check("abort busy", busy, 0);
    check("abort out_data", out_data, 8'h00);
    check("abort nar_seen", nar_seen, 0);
    @(negedge clk);
    rst_n = 1'b1;
    flen = 1;
    fa[0] = 8'h40;
    fb[0] = 8'h60;
    run_frame("post-reset", 0, 0, 1'b0, res, nar);
    check("post-reset out_data", res, 8'h60);
    check("post-reset nar_seen", nar, 0);

    // Directed frames.
    for (int t = 0; t < 10; t++) begin
      flen = tbl[t].n;
      for (int j = 0; j < flen; j++) begin
        fa[j] = tbl[t].a[8*j +: 8];
        fb[j] = tbl[t].b[8*j +: 8];
      end
      run_frame($sformatf("vec%0d", t), tbl[t].gap, tbl[t].hold, tbl[t].noise, res, nar);
      check($sformatf("vec%0d out_data", t), res, tbl[t].exp_res);
      check($sformatf("vec%0d nar_seen", t), nar, tbl[t].exp_nar);
    end

    // Cycle-exact latency: len=4 back-to-back, out_ready held high.
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    len   = 8'd4;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("lat out_valid c%0d", c), out_valid, (c == 5) ? 1 : 0);
      check($sformatf("lat busy c%0d", c), busy, (c <= 5) ? 1 : 0);
      if (c == 5) begin
        check("lat out_data", out_data, 8'h70);
        check("lat nar_seen", nar_seen, 0);
      end
      in_valid = (c <= 4);
      in_a = 8'h40;
      in_b = 8'h40;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // len=0: result the cycle after start, in_ready never asserted.
`ifdef POSIT_DOT_BIAS_EN
    bias = 8'h20;
    exp  = 8'h20;
`else
    exp  = 8'h00;
`endif
    flen = 0;
    run_frame("len0", 0, 2, 1'b0, res, nar);
    check("len0 out_data", res, exp);
    check("len0 nar_seen", nar, 0);

    // Random frames against the model.
    for (int f = 0; f < 60; f++) begin
      flen = ($urandom_range(9) == 0) ? 0 : $urandom_range(10, 1);
      for (int j = 0; j < flen; j++) begin
        fa[j] = ($urandom_range(19) == 0) ? 8'h80 : 8'($urandom);
        fb[j] = ($urandom_range(19) == 0) ? 8'h80 : 8'($urandom);
      end
`ifdef POSIT_DOT_BIAS_EN
      bias = ($urandom_range(19) == 0) ? 8'h80 : 8'($urandom);
`endif
      exp = frame_model(exp_nar);
      run_frame($sformatf("rnd%0d", f), -1, $urandom_range(2), 1'b1, res, nar);
      check($sformatf("rnd%0d out_data", f), res, exp);
      check($sformatf("rnd%0d nar_seen", f), nar, exp_nar);
    end

    // Maximum length frame.
    flen = 255;
    for (int j = 0; j < flen; j++) begin
      fa[j] = 8'($urandom_range(255, 129));
      fb[j] = 8'($urandom_range(127));
    end
`ifdef POSIT_DOT_BIAS_EN
    bias = 8'h40;
`endif
    exp = frame_model(exp_nar);
    run_frame("maxlen", 0, 0, 1'b0, res, nar);
    check("maxlen out_data", res, exp);
    check("maxlen nar_seen", nar, exp_nar);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
